// File: rtl/router_inject_ni.sv
// rtl/router_inject_ni.sv - NoC injection stage: descriptor/payload intake, payload FIFO, credit-gated flit emission
//
// Purpose: accepts packet descriptors and payload words from the local core,
// buffers the payload, and sends head/body/tail flits to one router input port.
// A flit goes out only when a credit is available; the router returns credits
// as single-cycle pulses on flow_ctrl_in.
//
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-low reset
//   router_address   own node address, placed in the head flit source field
//   pkt_valid/ready  descriptor handshake; pkt_dest, pkt_len (payload flits 0..15)
//   data_valid/ready payload handshake; data_in is the payload word
//   channel_out      registered flit: [0]=valid [1]=head [2]=tail [3:]=payload
//   flow_ctrl_in     credit-return pulse from the router
//   busy             a packet is in progress
//   error            sticky: credit returned while already holding MAX_CREDITS
module router_inject_ni #(
  parameter int ROUTER_ADDR_WIDTH = 4,
  parameter int FLIT_DATA_WIDTH   = 31,
  parameter int CHANNEL_WIDTH     = FLIT_DATA_WIDTH + 3,
  parameter int FIFO_DEPTH        = 4,
  parameter int MAX_CREDITS       = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ROUTER_ADDR_WIDTH-1:0] router_address,
  input  logic                         pkt_valid,
  output logic                         pkt_ready,
  input  logic [ROUTER_ADDR_WIDTH-1:0] pkt_dest,
  input  logic [3:0]                   pkt_len,
  input  logic                         data_valid,
  output logic                         data_ready,
  input  logic [FLIT_DATA_WIDTH-1:0]   data_in,
  output logic [0:CHANNEL_WIDTH-1]     channel_out,
  input  logic                         flow_ctrl_in,
  output logic                         busy,
  output logic                         error
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CR_W  = $clog2(MAX_CREDITS + 1);
  localparam logic [PTR_W:0] DEPTH_C = FIFO_DEPTH[PTR_W:0];
  localparam logic [CR_W-1:0] MAX_C  = MAX_CREDITS[CR_W-1:0];

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  state_t                       state, state_next;
  logic [ROUTER_ADDR_WIDTH-1:0] dest_q;
  logic [3:0]                   len_q;
  logic [3:0]                   remaining;
  logic [CR_W-1:0]              credits;

  logic [FLIT_DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [PTR_W:0]               count;
  logic                         fifo_full, fifo_empty;
  logic                         push, pop, send;
  logic [0:CHANNEL_WIDTH-1]     flit_next;

  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == '0);
  assign data_ready = !fifo_full;
  assign pkt_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  // A push is only taken when ready was shown, so a word offered while full is dropped.
  assign push       = data_valid && !fifo_full;

  always_comb begin
    state_next = state;
    send       = 1'b0;
    pop        = 1'b0;
    flit_next  = '0;
    case (state)
      IDLE: begin
        if (pkt_valid) state_next = HEAD;
      end
      HEAD: begin
        if (credits != '0) begin
          send         = 1'b1;
          flit_next[0] = 1'b1;
          flit_next[1] = 1'b1;
          flit_next[2] = (len_q == 4'd0);
          flit_next[3 +: ROUTER_ADDR_WIDTH]                     = dest_q;
          flit_next[3 + ROUTER_ADDR_WIDTH +: ROUTER_ADDR_WIDTH] = router_address;
          flit_next[3 + 2*ROUTER_ADDR_WIDTH +: 4]               = len_q;
          state_next = (len_q == 4'd0) ? IDLE : BODY;
        end
      end
      BODY: begin
        if (credits != '0 && !fifo_empty) begin
          send         = 1'b1;
          pop          = 1'b1;
          flit_next[0] = 1'b1;
          flit_next[2] = (remaining == 4'd1);
          flit_next[3 +: FLIT_DATA_WIDTH] = mem[rd_ptr];
          if (remaining == 4'd1) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      dest_q      <= '0;
      len_q       <= '0;
      remaining   <= '0;
      channel_out <= '0;
    end else begin
      state       <= state_next;
      channel_out <= flit_next;
      if (state == IDLE && pkt_valid) begin
        dest_q <= pkt_dest;
        len_q  <= pkt_len;
      end
      if (state == HEAD && send) remaining <= len_q;
      else if (pop)              remaining <= remaining - 4'd1;
    end
  end

  // Simultaneous return and send cancel out; a return at full count saturates and flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits <= MAX_C;
      error   <= 1'b0;
    end else begin
      if (flow_ctrl_in && !send) begin
        if (credits == MAX_C) error <= 1'b1;
        else                  credits <= credits + 1'b1;
      end else if (send && !flow_ctrl_in) begin
        credits <= credits - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: tb/tb_router_inject_ni.sv
// tb/tb_router_inject_ni.sv - directed vector bench for router_inject_ni
module tb_router_inject_ni;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  router_address;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [3:0]  pkt_dest;
  logic [3:0]  pkt_len;
  logic        data_valid;
  logic        data_ready;
  logic [30:0] data_in;
  logic [0:33] channel_out;
  logic        flow_ctrl_in;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  router_inject_ni dut (
    .clk(clk), .reset(reset), .router_address(router_address),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_dest(pkt_dest), .pkt_len(pkt_len),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .channel_out(channel_out), .flow_ctrl_in(flow_ctrl_in), .busy(busy), .error(error)
  );

  typedef struct {
    logic        pv;
    logic [3:0]  dest;
    logic [3:0]  len;
    logic        dv;
    logic [30:0] data;
    logic        fc;
    logic [0:33] exp_ch;
    logic        exp_busy;
    logic        exp_dr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [0:33] head_flit(logic [3:0] d, logic [3:0] l, logic t);
    logic [0:33] f;
    f = '0;
    f[0] = 1'b1; f[1] = 1'b1; f[2] = t;
    f[3:6] = d; f[7:10] = 4'd2; f[11:14] = l;
    return f;
  endfunction

  function automatic logic [0:33] body_flit(logic [30:0] w, logic t);
    logic [0:33] f;
    f = '0;
    f[0] = 1'b1; f[2] = t; f[3:33] = w;
    return f;
  endfunction

  task automatic add(input logic pv, input logic [3:0] d, input logic [3:0] l,
                     input logic dv, input logic [30:0] w, input logic fc,
                     input logic [0:33] ch, input logic b, input logic dr, input logic e);
    vec_t v;
    v.pv = pv; v.dest = d; v.len = l; v.dv = dv; v.data = w; v.fc = fc;
    v.exp_ch = ch; v.exp_busy = b; v.exp_dr = dr; v.exp_err = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [0:33] ch, input logic b,
                               input logic dr, input logic e);
    check({tag, " channel_out"}, 64'(channel_out), 64'(ch));
    check({tag, " busy"},        64'(busy),        64'(b));
    check({tag, " pkt_ready"},   64'(pkt_ready),   64'(!b));
    check({tag, " data_ready"},  64'(data_ready),  64'(dr));
    check({tag, " error"},       64'(error),       64'(e));
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      pkt_valid    = vecs[i].pv;
      pkt_dest     = vecs[i].dest;
      pkt_len      = vecs[i].len;
      data_valid   = vecs[i].dv;
      data_in      = vecs[i].data;
      flow_ctrl_in = vecs[i].fc;
      @(posedge clk);
      @(negedge clk);
      check_outputs($sformatf("row%0d", i), vecs[i].exp_ch, vecs[i].exp_busy,
                    vecs[i].exp_dr, vecs[i].exp_err);
    end
  endtask

  localparam logic [30:0] WA = 31'h0AAA0001, WB = 31'h0BBB0002, WC = 31'h0CCC0003;
  localparam logic [30:0] WD = 31'h1DDD0004, WE = 31'h2EEE0005, WF = 31'h3FFF0006;
  localparam logic [30:0] WG = 31'h40010007, WH = 31'h51230008, WI = 31'h7FFFFFFF;
  localparam logic [30:0] W0 = 31'h00C0FFEE, W1 = 31'h01C0FFEE, W2 = 31'h02C0FFEE, W3 = 31'h03C0FFEE;
  localparam logic [30:0] X0 = 31'h12340000, X1 = 31'h12340001, X2 = 31'h12340002, X3 = 31'h12340003;

  initial begin
    logic [0:33] z;
    z = '0;
    reset = 1'b0;
    router_address = 4'd2;
    pkt_valid = 1'b0; pkt_dest = '0; pkt_len = '0;
    data_valid = 1'b0; data_in = '0; flow_ctrl_in = 1'b0;

    // pv d l dv data fc | channel busy data_ready error
    add(1, 5, 0, 0, 0,  0, z,                     1, 1, 0); // 0  len=0 descriptor
    add(0, 0, 0, 0, 0,  0, head_flit(5, 0, 1),    0, 1, 0); // 1  head+tail, credits 3
    add(0, 0, 0, 0, 0,  1, z,                     0, 1, 0); // 2  credits 4
    add(0, 0, 0, 1, WA, 0, z,                     0, 1, 0); // 3
    add(0, 0, 0, 1, WB, 0, z,                     0, 1, 0); // 4
    add(0, 0, 0, 1, WC, 0, z,                     0, 1, 0); // 5
    add(1, 3, 3, 0, 0,  0, z,                     1, 1, 0); // 6
    add(0, 0, 0, 0, 0,  0, head_flit(3, 3, 0),    1, 1, 0); // 7
    add(0, 0, 0, 0, 0,  0, body_flit(WA, 0),      1, 1, 0); // 8
    add(0, 0, 0, 0, 0,  0, body_flit(WB, 0),      1, 1, 0); // 9
    add(0, 0, 0, 0, 0,  0, body_flit(WC, 1),      0, 1, 0); // 10 tail, credits 0
    for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 0, 1, z, 0, 1, 0); // 11-14 back to 4
    add(0, 0, 0, 1, WD, 0, z,                     0, 1, 0); // 15
    add(0, 0, 0, 1, WE, 0, z,                     0, 1, 0); // 16
    add(0, 0, 0, 1, WF, 0, z,                     0, 1, 0); // 17
    add(0, 0, 0, 1, WG, 0, z,                     0, 0, 0); // 18 FIFO full
    add(1, 9, 6, 1, WH, 0, z,                     1, 0, 0); // 19 push while full dropped
    add(0, 0, 0, 0, 0,  0, head_flit(9, 6, 0),    1, 0, 0); // 20
    add(0, 0, 0, 0, 0,  0, body_flit(WD, 0),      1, 1, 0); // 21
    add(0, 0, 0, 0, 0,  0, body_flit(WE, 0),      1, 1, 0); // 22
    add(0, 0, 0, 0, 0,  0, body_flit(WF, 0),      1, 1, 0); // 23 credits 0
    add(0, 0, 0, 0, 0,  0, z,                     1, 1, 0); // 24 stall
    add(0, 0, 0, 0, 0,  0, z,                     1, 1, 0); // 25 stall
    add(0, 0, 0, 0, 0,  1, z,                     1, 1, 0); // 26 one credit back
    add(0, 0, 0, 0, 0,  0, body_flit(WG, 0),      1, 1, 0); // 27 exactly one more
    add(0, 0, 0, 0, 0,  0, z,                     1, 1, 0); // 28
    add(0, 0, 0, 0, 0,  1, z,                     1, 1, 0); // 29 credit, FIFO empty
    add(0, 0, 0, 0, 0,  0, z,                     1, 1, 0); // 30
    add(0, 0, 0, 0, 0,  0, z,                     1, 1, 0); // 31
    add(0, 0, 0, 0, 0,  0, z,                     1, 1, 0); // 32
    add(0, 0, 0, 1, WH, 0, z,                     1, 1, 0); // 33 push
    add(0, 0, 0, 0, 0,  0, body_flit(WH, 0),      1, 1, 0); // 34 sent next cycle
    add(0, 0, 0, 1, WI, 1, z,                     1, 1, 0); // 35
    add(0, 0, 0, 0, 0,  0, body_flit(WI, 1),      0, 1, 0); // 36 tail
    add(0, 0, 0, 0, 0,  1, z,                     0, 1, 0); // 37 credits 1
    add(0, 0, 0, 0, 0,  1, z,                     0, 1, 0); // 38 credits 2
    add(1, 1, 0, 0, 0,  0, z,                     1, 1, 0); // 39
    add(0, 0, 0, 0, 0,  1, head_flit(1, 0, 1),    0, 1, 0); // 40 send+return: stays 2
    add(0, 0, 0, 0, 0,  1, z,                     0, 1, 0); // 41 credits 3
    add(0, 0, 0, 0, 0,  1, z,                     0, 1, 0); // 42 credits 4
    add(0, 0, 0, 0, 0,  1, z,                     0, 1, 1); // 43 overflow
    add(0, 0, 0, 0, 0,  0, z,                     0, 1, 1); // 44 sticky
    add(0, 0, 0, 1, W0, 0, z,                     0, 1, 1); // 45
    add(0, 0, 0, 1, W1, 0, z,                     0, 1, 1); // 46
    add(0, 0, 0, 1, W2, 0, z,                     0, 1, 1); // 47
    add(0, 0, 0, 1, W3, 0, z,                     0, 0, 1); // 48
    add(1, 7, 5, 0, 0,  0, z,                     1, 0, 1); // 49
    add(0, 0, 0, 0, 0,  0, head_flit(7, 5, 0),    1, 0, 1); // 50
    add(0, 0, 0, 0, 0,  0, body_flit(W0, 0),      1, 1, 1); // 51
    add(0, 0, 0, 0, 0,  0, body_flit(W1, 0),      1, 1, 1); // 52 2 of 5 sent
    add(0, 0, 0, 1, X0, 0, z,                     0, 1, 0); // 53 after reset
    add(0, 0, 0, 1, X1, 0, z,                     0, 1, 0); // 54
    add(0, 0, 0, 1, X2, 0, z,                     0, 1, 0); // 55
    add(0, 0, 0, 1, X3, 0, z,                     0, 0, 0); // 56 flushed FIFO fills at 4
    add(1, 4, 4, 0, 0,  0, z,                     1, 0, 0); // 57
    add(0, 0, 0, 0, 0,  0, head_flit(4, 4, 0),    1, 0, 0); // 58
    add(0, 0, 0, 0, 0,  0, body_flit(X0, 0),      1, 1, 0); // 59
    add(0, 0, 0, 0, 0,  0, body_flit(X1, 0),      1, 1, 0); // 60
    add(0, 0, 0, 0, 0,  0, body_flit(X2, 0),      1, 1, 0); // 61 four credits used
    add(0, 0, 0, 0, 0,  0, z,                     1, 1, 0); // 62 stall
    add(0, 0, 0, 0, 0,  0, z,                     1, 1, 0); // 63 stall

    repeat (2) @(negedge clk);
    check_outputs("in_reset", z, 0, 1, 0);
    reset = 1'b1;
    @(negedge clk);
    check_outputs("post_reset", z, 0, 1, 0);

    run_rows(0, 52);

    // Mid-packet abort: outputs must clear without waiting for a clock edge.
    #2 reset = 1'b0;
    #1 check_outputs("async_reset", z, 0, 1, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_outputs("reset_release", z, 0, 1, 0);

    run_rows(53, 63);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
